uart_baud_gen: RTL and testbench

Parametrised successor to the fixed dual-divider UART tick generator. A single integer+fractional prescaler produces the oversample tick. An OSR-deep phase counter derives the mid-bit sample tick and the bit tick from it, so RX and TX share one programmed rate. Adds glitch-free divider reload, RX phase resync on start-bit detect, and run enable. Sits between CTRL/STATUS CSRs and the TX/RX FSMs.

---
 rtl/uart_baud_gen.sv | 120 ++++++++++++
 tb/tb_uart_baud_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: shared UART oversample/mid-bit/bit tick generator with integer+fractional prescaler.
// Optional fractional divider enabled by defining UART_BAUD_FRAC_EN; without it div_frac is ignored.
module uart_baud_gen #(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int OSR = 16,
  localparam int PH_W = $clog2(OSR)
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              cfg_update,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_pending
);
  logic [DIV_W:0]     cnt_q, cnt_d, limit;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [DIV_W-1:0]   act_int_q, act_int_d;
  logic               pend_q, pend_d, os_q, os_d, mid_q, mid_d, bit_q, bit_d;
  logic               term, load;
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0]  acc_q, acc_d, act_frac_q, act_frac_d;
  logic               ext_q, ext_d;
`else
  logic               ext_q;
  logic               unused_frac;
  assign ext_q = 1'b0;
  assign unused_frac = ^div_frac;
`endif
  // A carry from the fractional accumulator stretches the current os period by one cycle.
  assign limit = {1'b0, act_int_q} + (DIV_W+1)'(ext_q);
  assign term = cnt_q == limit;
  // Pending config is only taken at a bit boundary so a frame never sees a mid-bit rate change.
  assign load = en & pend_q & bit_q;
  // Prescaler, phase counter, tick generation and config staging.
  always_comb begin
    cnt_d = cnt_q;
    phase_d = phase_q;
    act_int_d = load ? div_int : act_int_q;
    pend_d = en & (cfg_update | (pend_q & ~bit_q));
    os_d = 1'b0;
    mid_d = 1'b0;
    bit_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      phase_d = '0;
      act_int_d = div_int;
    end else if (rx_resync) begin
      cnt_d = (act_int_q == '0) ? '0 : (DIV_W+1)'(1);
      phase_d = '0;
    end else if (term) begin
      cnt_d = '0;
      os_d = 1'b1;
      mid_d = phase_q == PH_W'(OSR/2-1);
      bit_d = phase_q == PH_W'(OSR-1);
      phase_d = (phase_q == PH_W'(OSR-1)) ? '0 : phase_q + PH_W'(1);
    end else begin
      cnt_d = cnt_q + (DIV_W+1)'(1);
    end
  end
  // State register for prescaler, phase, active divider and registered ticks.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase_q <= '0;
      act_int_q <= '0;
      pend_q <= 1'b0;
      os_q <= 1'b0;
      mid_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      act_int_q <= act_int_d;
      pend_q <= pend_d;
      os_q <= os_d;
      mid_q <= mid_d;
      bit_q <= bit_d;
    end
  end
`ifdef UART_BAUD_FRAC_EN
  // Fractional accumulator: advances once per os period, cleared when idle or resynced.
  always_comb begin
    acc_d = acc_q;
    ext_d = ext_q;
    act_frac_d = load ? div_frac : act_frac_q;
    if (!en) begin
      acc_d = '0;
      ext_d = 1'b0;
      act_frac_d = div_frac;
    end else if (rx_resync) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (term) begin
      {ext_d, acc_d} = (FRAC_W+1)'(acc_q) + (FRAC_W+1)'(act_frac_q);
    end
  end
  // Fractional state register.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ext_q <= 1'b0;
      act_frac_q <= '0;
    end else begin
      acc_q <= acc_d;
      ext_q <= ext_d;
      act_frac_q <= act_frac_d;
    end
  end
`endif
  assign os_tick = os_q;
  assign mid_tick = mid_q;
  assign bit_tick = bit_q;
  assign cfg_pending = pend_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: table-driven and sequence checks of uart_baud_gen against a cycle model scoreboard.
module tb_uart_baud_gen;
  localparam int DIV_W = 16, FRAC_W = 4, OSR = 16;
  logic clk_50mhz = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_update = 1'b0, rx_resync = 1'b0;
  logic [DIV_W-1:0] div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic os_tick, mid_tick, bit_tick, cfg_pending;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] hist[512];
  int m_cnt, m_phase, m_acc, m_ext, m_ai, m_af;
  bit m_pend, m_os, m_mid, m_bit;
  typedef struct {int di; int df; int fo; int fm; int fb;} row_t;
  row_t rows[5];

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .en(en), .div_int(div_int), .div_frac(div_frac),
    .cfg_update(cfg_update), .rx_resync(rx_resync), .os_tick(os_tick), .mid_tick(mid_tick),
    .bit_tick(bit_tick), .cfg_pending(cfg_pending)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic summary_and_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      if (miscompares > 40) summary_and_end();
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_acc = 0; m_ext = 0; m_ai = 0; m_af = 0;
    m_pend = 0; m_os = 0; m_mid = 0; m_bit = 0;
  endtask

  task automatic model_step();
    int lim;
    bit ld;
    if (!en) begin
      model_reset();
      m_ai = int'(div_int);
      m_af = int'(div_frac);
    end else begin
      lim = m_ai + m_ext;
      ld = m_pend && m_bit;
      m_pend = cfg_update || (m_pend && !m_bit);
      if (rx_resync) begin
        m_cnt = (m_ai == 0) ? 0 : 1;
        m_phase = 0; m_acc = 0; m_ext = 0; m_os = 0; m_mid = 0; m_bit = 0;
      end else if (m_cnt == lim) begin
        m_cnt = 0;
        m_os = 1;
        m_mid = (m_phase == OSR/2-1);
        m_bit = (m_phase == OSR-1);
        m_phase = (m_phase + 1) % OSR;
`ifdef UART_BAUD_FRAC_EN
        m_acc = m_acc + m_af;
        m_ext = (m_acc >= (1 << FRAC_W)) ? 1 : 0;
        m_acc = m_acc % (1 << FRAC_W);
`endif
      end else begin
        m_cnt++;
        m_os = 0; m_mid = 0; m_bit = 0;
      end
      if (ld) begin
        m_ai = int'(div_int);
        m_af = int'(div_frac);
      end
    end
  endtask

  task automatic step();
    logic [3:0] e;
    model_step();
    exp_q.push_back({m_os, m_mid, m_bit, m_pend});
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    e = exp_q.pop_front();
    vectors++;
    if ({os_tick, mid_tick, bit_tick, cfg_pending} !== e) begin
      miscompares++;
      $display("FAIL scb cyc=%0d got os/mid/bit/pend=%b expected %b", cyc + 1,
               {os_tick, mid_tick, bit_tick, cfg_pending}, e);
      if (miscompares > 40) summary_and_end();
    end
    cyc++;
    if (cyc < 512) hist[cyc] = {os_tick, mid_tick, bit_tick, cfg_pending};
  endtask

  task automatic idle(input int di, input int df);
    en = 0; cfg_update = 0; rx_resync = 0;
    div_int = DIV_W'(di);
    div_frac = FRAC_W'(df);
    step();
    step();
  endtask

  task automatic start();
    for (int i = 0; i < 512; i++) hist[i] = '0;
    en = 1;
    cyc = 0;
    hist[0] = {os_tick, mid_tick, bit_tick, cfg_pending};
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic int first(input int b);
    for (int i = 0; i < 512; i++) if (hist[i][b]) return i;
    return -1;
  endfunction

  function automatic int h(input int c, input int b);
    return int'(hist[c][b]);
  endfunction

  initial begin
    rows[0] = '{3, 0, 4, 32, 64};
    rows[1] = '{0, 0, 1, 8, 16};
    rows[2] = '{1, 0, 2, 16, 32};
    rows[3] = '{6, 0, 7, 56, 112};
`ifdef UART_BAUD_FRAC_EN
    rows[4] = '{2, 8, 3, 27, 55};
`else
    rows[4] = '{2, 8, 3, 24, 48};
`endif
    model_reset();
    @(negedge clk_50mhz);
    chk("rst_os", int'(os_tick), 0);
    chk("rst_mid", int'(mid_tick), 0);
    chk("rst_bit", int'(bit_tick), 0);
    chk("rst_pend", int'(cfg_pending), 0);
    rst_n = 1;

    for (int r = 0; r < 5; r++) begin
      idle(rows[r].di, rows[r].df);
      start();
      run_to(rows[r].fb + 3);
      chk($sformatf("row%0d_first_os", r), first(3), rows[r].fo);
      chk($sformatf("row%0d_first_mid", r), first(2), rows[r].fm);
      chk($sformatf("row%0d_first_bit", r), first(1), rows[r].fb);
    end

    idle(3, 0);
    start();
    run_to(132);
    chk("basic_os8", h(8, 3), 1);
    chk("basic_os5", h(5, 3), 0);
    chk("basic_mid96", h(96, 2), 1);
    chk("basic_bit96", h(96, 1), 0);
    chk("basic_bit128", h(128, 1), 1);

    idle(3, 0);
    start();
    while (cyc < 90) begin
      rx_resync = (cyc == 21);
      step();
    end
    rx_resync = 0;
    chk("resync_os22", h(22, 3), 0);
    chk("resync_os24", h(24, 3), 0);
    chk("resync_os25", h(25, 3), 1);
    chk("resync_os29", h(29, 3), 1);
    chk("resync_mid53", h(53, 2), 1);
    chk("resync_bit85", h(85, 1), 1);

    idle(3, 0);
    start();
    while (cyc < 90) begin
      cfg_update = (cyc == 10);
      div_int = (cyc >= 10) ? DIV_W'(7) : DIV_W'(3);
      step();
    end
    cfg_update = 0;
    chk("reload_pend10", h(10, 0), 0);
    chk("reload_pend11", h(11, 0), 1);
    chk("reload_pend64", h(64, 0), 1);
    chk("reload_pend65", h(65, 0), 0);
    chk("reload_os64", h(64, 3), 1);
    chk("reload_os68", h(68, 3), 0);
    chk("reload_os72", h(72, 3), 1);
    chk("reload_os80", h(80, 3), 1);

    idle(3, 0);
    start();
    while (cyc < 130) begin
      rx_resync = (cyc == 63);
      step();
    end
    rx_resync = 0;
    chk("simul_bit64", h(64, 1), 0);
    chk("simul_os64", h(64, 3), 0);
    chk("simul_mid95", h(95, 2), 1);
    chk("simul_bit127", h(127, 1), 1);

    idle(0, 0);
    start();
    while (cyc < 12) begin
      cfg_update = (cyc == 3);
      en = (cyc < 6);
      rx_resync = (cyc == 6);
      step();
    end
    cfg_update = 0; rx_resync = 0;
    chk("en_os1", h(1, 3), 1);
    chk("en_os5", h(5, 3), 1);
    chk("en_os7", h(7, 3), 0);
    chk("en_pend4", h(4, 0), 1);
    chk("en_pend7", h(7, 0), 0);

    idle(3, 0);
    start();
    while (cyc < 40) begin
      cfg_update = (cyc == 20);
      step();
    end
    cfg_update = 0;
    chk("pre_rst_os40", int'(os_tick), 1);
    chk("pre_rst_pend40", int'(cfg_pending), 1);
    #3 rst_n = 0;
    en = 0;
    #1;
    chk("async_rst_os", int'(os_tick), 0);
    chk("async_rst_mid", int'(mid_tick), 0);
    chk("async_rst_bit", int'(bit_tick), 0);
    chk("async_rst_pend", int'(cfg_pending), 0);
    model_reset();
    @(negedge clk_50mhz);
    rst_n = 1;
    idle(3, 0);
    start();
    run_to(70);
    chk("restart_first_os", first(3), 4);
    chk("restart_first_mid", first(2), 32);
    chk("restart_first_bit", first(1), 64);
    idle(3, 0);
    summary_and_end();
  end
endmodule
